less_flag: RTL and testbench

- Registered "less-than" flag generator for the RISC-V datapath. Feeds the branch unit (BLT/BLTU) and SLT/SLTU result selection.
- Compares two WORDSIZE-bit operands and raises `less` when input_a < input_b.
- Comparison is signed (two's complement) or unsigned, selected per request.
- Result is registered with a valid flag, giving one cycle of latency.

---
 rtl/alu_flags_pkg.sv | 19 +
 rtl/less_sub_core.sv | 29 ++
 rtl/less_flag.sv | 80 ++++++++
 tb/tb_less_flag.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/alu_flags_pkg.sv
// Shared definitions for the ALU flag generators: default word width, compare mode
// and a helper that picks the signed or unsigned less-than result.

package alu_flags_pkg;

    localparam int unsigned DEFAULT_WORDSIZE = 64;

    typedef enum logic {
        CMP_SIGNED   = 1'b0,
        CMP_UNSIGNED = 1'b1
    } cmp_mode_e;

    typedef logic [DEFAULT_WORDSIZE-1:0] word_t;

    function automatic logic sel_less(input cmp_mode_e mode, input logic lt_u, input logic lt_s);
        return (mode == CMP_UNSIGNED) ? lt_u : lt_s;
    endfunction

endpackage

// File: rtl/less_sub_core.sv
// Combinational (WORDSIZE+1)-bit subtractor producing borrow, sign, overflow and zero flags
// for a - b.

module less_sub_core #(
    parameter int unsigned WORDSIZE = 64
) (
    input  logic [WORDSIZE-1:0] i_a,
    input  logic [WORDSIZE-1:0] i_b,
    output logic                o_c,
    output logic                o_n,
    output logic                o_v,
    output logic                o_zero
);

    logic [WORDSIZE:0] w_diff;
    logic              w_a_msb;
    logic              w_b_msb;

    // Zero-extended operands: the extra top bit of the difference is the borrow out.
    assign w_diff  = {1'b0, i_a} - {1'b0, i_b};
    assign w_a_msb = i_a[WORDSIZE-1];
    assign w_b_msb = i_b[WORDSIZE-1];

    assign o_c    = w_diff[WORDSIZE];
    assign o_n    = w_diff[WORDSIZE-1];
    assign o_v    = (w_a_msb ^ w_b_msb) & (w_a_msb ^ w_diff[WORDSIZE-1]);
    assign o_zero = (w_diff[WORDSIZE-1:0] == '0);

endmodule

// File: rtl/less_flag.sv
// Registered less-than flag (signed/unsigned) with one cycle of latency and a valid flag.
// Optional registered equal output enabled by defining LESS_FLAG_EQUAL_EN.

module less_flag
    import alu_flags_pkg::*;
#(
    parameter int unsigned WORDSIZE = DEFAULT_WORDSIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic                is_unsigned,
    input  logic [WORDSIZE-1:0] input_a,
    input  logic [WORDSIZE-1:0] input_b,
`ifdef LESS_FLAG_EQUAL_EN
    output logic                equal,
`endif
    output logic                less,
    output logic                out_valid
);

    logic      w_c;
    logic      w_n;
    logic      w_v;
    logic      w_zero;
    logic      w_lt_u;
    logic      w_lt_s;
    logic      w_less;
    cmp_mode_e w_mode;

    logic      r_less;
    logic      r_valid;

    less_sub_core #(
        .WORDSIZE (WORDSIZE)
    ) u_sub_core (
        .i_a    (input_a),
        .i_b    (input_b),
        .o_c    (w_c),
        .o_n    (w_n),
        .o_v    (w_v),
        .o_zero (w_zero)
    );

    assign w_mode = cmp_mode_e'(is_unsigned);
    assign w_lt_u = w_c;
    assign w_lt_s = w_n ^ w_v;
    // Zero gating is redundant with the flag math but makes the equal-operand case explicit.
    assign w_less = sel_less(w_mode, w_lt_u, w_lt_s) & ~w_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_less  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_less <= w_less;
            end
        end
    end

    assign less      = r_less;
    assign out_valid = r_valid;

`ifdef LESS_FLAG_EQUAL_EN
    logic r_equal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_equal <= 1'b0;
        end else if (in_valid) begin
            r_equal <= w_zero;
        end
    end

    assign equal = r_equal;
`endif

endmodule

// File: tb/tb_less_flag.sv
// Directed self-checking bench for less_flag with hand-computed expectations.
// Covers the equal output as well when LESS_FLAG_EQUAL_EN is defined.

module tb_less_flag;

    localparam int unsigned W = 64;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         is_unsigned;
    logic [W-1:0] input_a;
    logic [W-1:0] input_b;
    logic         less;
    logic         out_valid;
`ifdef LESS_FLAG_EQUAL_EN
    logic         equal;
`endif

    int n_checks;
    int n_errors;

    less_flag #(
        .WORDSIZE (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .is_unsigned (is_unsigned),
        .input_a     (input_a),
        .input_b     (input_b),
`ifdef LESS_FLAG_EQUAL_EN
        .equal       (equal),
`endif
        .less        (less),
        .out_valid   (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Drive a request at the falling edge, then sample just after the next rising edge.
    task automatic req(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic uns, input logic exp_less);
        @(negedge clk);
        in_valid    = 1'b1;
        is_unsigned = uns;
        input_a     = a;
        input_b     = b;
        @(posedge clk);
        #1;
        check({tag, "_less"}, {63'd0, less}, {63'd0, exp_less});
        check({tag, "_vld"}, {63'd0, out_valid}, 64'd1);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        is_unsigned = 1'b0;
        input_a     = '0;
        input_b     = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_less", {63'd0, less}, 64'd0);
        check("rst_vld", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_vld", {63'd0, out_valid}, 64'd0);

        // Signed basics
        req("s_5_2", 64'h5, 64'h2, 1'b0, 1'b0);
        req("s_5_5", 64'h5, 64'h5, 1'b0, 1'b0);
        req("s_1_5", 64'h1, 64'h5, 1'b0, 1'b1);
        req("s_1_big", 64'h1, 64'h1000_0000_0000_0001, 1'b0, 1'b1);
        req("u_5_5", 64'h5, 64'h5, 1'b1, 1'b0);

        // Negative vs zero
        req("s_m1_0", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b0, 1'b1);
        req("u_m1_0", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0);
        req("u_0_m1", 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

        // Overflow boundary
        req("s_min_max", 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        req("u_min_max", 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        req("s_max_min", 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 1'b0);
        req("u_max_min", 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 1'b1);

        // Back-to-back then a gap; operands during the gap would give less=0
        req("b2b_0", 64'h3, 64'h9, 1'b1, 1'b1);
        req("b2b_1", 64'h9, 64'h3, 1'b1, 1'b0);
        req("b2b_2", 64'hFFFF_FFFF_FFFF_FFFE, 64'h2, 1'b0, 1'b1);
        @(negedge clk);
        in_valid    = 1'b0;
        is_unsigned = 1'b1;
        input_a     = 64'h9;
        input_b     = 64'h1;
        @(posedge clk);
        #1;
        check("gap_vld", {63'd0, out_valid}, 64'd0);
        check("gap_hold", {63'd0, less}, 64'd1);

        // Asynchronous reset mid-request
        req("pre_rst", 64'h1, 64'h2, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_less", {63'd0, less}, 64'd0);
        check("arst_vld", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        check("rst_hold_less", {63'd0, less}, 64'd0);
        check("rst_hold_vld", {63'd0, out_valid}, 64'd0);
        idle();
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_vld", {63'd0, out_valid}, 64'd0);
        check("post_rst_less", {63'd0, less}, 64'd0);
        req("post_rst_req", 64'h2, 64'h7, 1'b0, 1'b1);

`ifdef LESS_FLAG_EQUAL_EN
        req("eq_same", 64'h1234, 64'h1234, 1'b0, 1'b0);
        check("eq_same_eq", {63'd0, equal}, 64'd1);
        req("eq_diff", 64'h1234, 64'h1235, 1'b1, 1'b1);
        check("eq_diff_eq", {63'd0, equal}, 64'd0);
        req("eq_same_u", 64'h1234, 64'h1234, 1'b1, 1'b0);
        check("eq_same_u_eq", {63'd0, equal}, 64'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("eq_rst", {63'd0, equal}, 64'd0);
        reset = 1'b0;
`endif

        idle();
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
